clk_div_multi: RTL and testbench

//  Multi-channel programmable clock-enable / divided-clock generator.

---
 rtl/clk_div_multi.sv | 98 +++++++++
 tb/tb_clk_div_multi.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_multi.sv
// rtl/clk_div_multi.sv - multi-channel programmable clock divider with glitch-free ratio update
// Each channel counts 0..div-1 and emits a registered tick plus a pulse or square divided output.
module clk_div_multi #(
    parameter int NUM_CH      = 4,
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 16,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] en,
    input  logic              sync,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic              cfg_mode,
    output logic [NUM_CH-1:0] div_out,
    output logic [NUM_CH-1:0] tick
);

    logic [NUM_CH-1:0][DIV_W-1:0] cnt_q, cnt_d;
    logic [NUM_CH-1:0][DIV_W-1:0] div_q, div_d;
    logic [NUM_CH-1:0][DIV_W-1:0] pend_div_q, pend_div_d;
    logic [NUM_CH-1:0]            mode_q, mode_d;
    logic [NUM_CH-1:0]            pend_mode_q, pend_mode_d;
    logic [NUM_CH-1:0]            pend_valid_q, pend_valid_d;
    logic [NUM_CH-1:0]            div_out_q, div_out_d;
    logic [NUM_CH-1:0]            tick_q, tick_d;
    logic [NUM_CH-1:0]            tc;
    logic [DIV_W-1:0]             cfg_div_clamped;

    assign div_out = div_out_q;
    assign tick    = tick_q;
    assign cfg_div_clamped = (cfg_div < DIV_W'(2)) ? DIV_W'(2) : cfg_div;

    // Out-of-range channel numbers match nothing, so such writes are accepted and dropped.
    always_comb begin
        cfg_ready = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_ch == CH_W'(i)) begin
                cfg_ready = ~pend_valid_q[i];
            end
        end
    end

    always_comb begin
        cnt_d        = cnt_q;
        div_d        = div_q;
        mode_d       = mode_q;
        pend_div_d   = pend_div_q;
        pend_mode_d  = pend_mode_q;
        pend_valid_d = pend_valid_q;
        div_out_d    = '0;
        tick_d       = '0;
        tc           = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            tc[i]        = (cnt_q[i] == div_q[i] - DIV_W'(1));
            cnt_d[i]     = (en[i] && !tc[i] && !sync) ? cnt_q[i] + DIV_W'(1) : '0;
            tick_d[i]    = en[i] & tc[i];
            div_out_d[i] = en[i] & (mode_q[i] ? (cnt_q[i] < (div_q[i] >> 1)) : tc[i]);
            // Apply only at a period boundary (or while idle) so no runt period is produced.
            if (pend_valid_q[i] && (tc[i] || !en[i] || sync)) begin
                div_d[i]        = pend_div_q[i];
                mode_d[i]       = pend_mode_q[i];
                pend_valid_d[i] = 1'b0;
            end
            if (cfg_valid && cfg_ready && (cfg_ch == CH_W'(i))) begin
                pend_div_d[i]   = cfg_div_clamped;
                pend_mode_d[i]  = cfg_mode;
                pend_valid_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            div_q        <= {NUM_CH{DIV_W'(DEFAULT_DIV)}};
            mode_q       <= '0;
            pend_div_q   <= '0;
            pend_mode_q  <= '0;
            pend_valid_q <= '0;
            div_out_q    <= '0;
            tick_q       <= '0;
        end else begin
            cnt_q        <= cnt_d;
            div_q        <= div_d;
            mode_q       <= mode_d;
            pend_div_q   <= pend_div_d;
            pend_mode_q  <= pend_mode_d;
            pend_valid_q <= pend_valid_d;
            div_out_q    <= div_out_d;
            tick_q       <= tick_d;
        end
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// tb/tb_clk_div_multi.sv - self-checking bench for clk_div_multi
// Reference model tracks each channel by period start time and ratio, with a one-deep pending slot.
module tb_clk_div_multi;

    localparam int NUM_CH = 4;
    localparam int DIV_W  = 16;
    localparam int DEF    = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NUM_CH-1:0] en = '0;
    logic              sync = 1'b0;
    logic              cfg_valid = 1'b0;
    logic              cfg_ready;
    logic [1:0]        cfg_ch = '0;
    logic [DIV_W-1:0]  cfg_div = '0;
    logic              cfg_mode = 1'b0;
    logic [NUM_CH-1:0] div_out;
    logic [NUM_CH-1:0] tick;

    clk_div_multi #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .DEFAULT_DIV(DEF)) dut (
        .clk(clk), .rst(rst), .en(en), .sync(sync),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
        .cfg_div(cfg_div), .cfg_mode(cfg_mode),
        .div_out(div_out), .tick(tick)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    int cyc = 0;
    bit m_init = 0;
    int m_start[NUM_CH];
    int m_n[NUM_CH];
    bit m_mode[NUM_CH];
    bit m_pv[NUM_CH];
    int m_pn[NUM_CH];
    bit m_pm[NUM_CH];

    typedef struct {
        int div;
        bit mode;
        int period;
        int highs;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    // One clock: check cfg_ready, predict outputs, clock, compare, advance the model.
    task automatic step();
        logic [NUM_CH-1:0] e_tick, e_div;
        bit tcs[NUM_CH];
        bit rdy;
        int ph;
        #1;
        rdy = (int'(cfg_ch) >= NUM_CH) ? 1'b1 : !m_pv[cfg_ch];
        if (m_init) chk("cfg_ready", {31'd0, cfg_ready}, {31'd0, rdy});
        for (int i = 0; i < NUM_CH; i++) begin
            ph = cyc - m_start[i];
            tcs[i] = (ph == m_n[i] - 1);
            e_tick[i] = !rst && en[i] && tcs[i];
            e_div[i]  = !rst && en[i] && (m_mode[i] ? (ph < m_n[i] / 2) : tcs[i]);
        end
        @(posedge clk);
        #1;
        chk("tick", {28'd0, tick}, {28'd0, e_tick});
        chk("div_out", {28'd0, div_out}, {28'd0, e_div});
        for (int i = 0; i < NUM_CH; i++) begin
            if (rst) begin
                m_start[i] = cyc + 1;
                m_n[i] = DEF;
                m_mode[i] = 0;
                m_pv[i] = 0;
            end else begin
                if (m_pv[i] && (tcs[i] || !en[i] || sync)) begin
                    m_n[i] = m_pn[i];
                    m_mode[i] = m_pm[i];
                    m_pv[i] = 0;
                end
                if (!en[i] || tcs[i] || sync) m_start[i] = cyc + 1;
                if (cfg_valid && rdy && int'(cfg_ch) == i) begin
                    m_pv[i] = 1;
                    m_pn[i] = (cfg_div < 2) ? 2 : int'(cfg_div);
                    m_pm[i] = cfg_mode;
                end
            end
        end
        if (rst) m_init = 1;
        cyc++;
    endtask

    // Steps until tick[ch] is seen; n is the number of steps taken.
    task automatic measure(input int ch, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!tick[ch] && n < 200);
        if (!tick[ch]) chk("tick_timeout", 32'd0, 32'd1);
    endtask

    task automatic cfg_idle(input int ch, input int div, input bit mode);
        cfg_valid = 1; cfg_ch = 2'(ch); cfg_div = DIV_W'(div); cfg_mode = mode;
        step();
        cfg_valid = 0;
        step();
    endtask

    initial begin
        vec_t vt[7];
        int n, n2, hi;

        vt[0] = '{0, 0, 2, 1};
        vt[1] = '{1, 1, 2, 1};
        vt[2] = '{5, 1, 5, 2};
        vt[3] = '{7, 1, 7, 3};
        vt[4] = '{16, 0, 16, 1};
        vt[5] = '{2, 1, 2, 1};
        vt[6] = '{3, 0, 3, 1};

        // Reset defaults
        rst = 1; step(); step();
        rst = 0;
        #1 chk("reset_ready", {31'd0, cfg_ready}, 32'd1);
        en = 4'b0001;
        measure(0, n);
        chk("reset_first_period", n, 16);
        measure(0, n);
        chk("reset_period", n, 16);

        // Table of ratios on ch1: period and high-cycle count per period
        en = 4'b0000;
        for (int k = 0; k < 7; k++) begin
            en = 4'b0000;
            cfg_idle(1, vt[k].div, vt[k].mode);
            step();
            en = 4'b0010;
            measure(1, n);
            n = 0; hi = 0;
            do begin
                step();
                n++;
                hi += int'(div_out[1]);
            end while (!tick[1] && n < 200);
            chk($sformatf("tbl%0d_period", k), n, vt[k].period);
            chk($sformatf("tbl%0d_highs", k), hi, vt[k].highs);
        end

        // Glitch-free update: N=10 running, write N=3 at cnt=4
        en = 4'b0000;
        cfg_idle(0, 10, 0);
        en = 4'b0001;
        measure(0, n);
        repeat (4) step();
        cfg_valid = 1; cfg_ch = 0; cfg_div = 3; cfg_mode = 0;
        step();
        cfg_valid = 0;
        #1 chk("upd_ready_low", {31'd0, cfg_ready}, 32'd0);
        measure(0, n);
        chk("upd_old_period", n + 5, 10);
        #1 chk("upd_ready_back", {31'd0, cfg_ready}, 32'd1);
        measure(0, n);
        chk("upd_new_period", n, 3);

        // Backpressure: two back-to-back writes, second stalls until TC
        cfg_valid = 1; cfg_ch = 0; cfg_div = 4; cfg_mode = 0;
        step();
        cfg_div = 6; n2 = 0;
        do begin
            #1;
            if (!cfg_ready) n2++;
            step();
        end while (n2 < 200 && !(cfg_ready === 1'b0 ? 1'b0 : (n2 > 0 && m_pv[0] && m_pn[0] == 6)));
        cfg_valid = 0;
        chk("bp_stalled", {31'd0, n2 > 0}, 32'd1);
        measure(0, n);
        measure(0, n);
        chk("bp_final_period", n, 6);

        // Sync: ch0 N=4, ch1 N=6 misaligned, then sync aligns them
        en = 4'b0000;
        cfg_idle(0, 4, 0);
        cfg_idle(1, 6, 0);
        en = 4'b0001;
        repeat (3) step();
        en = 4'b0011;
        repeat (5) step();
        sync = 1; step(); sync = 0;
        for (int k = 1; k <= 24; k++) begin
            step();
            if (k == 4) chk("sync_ch0_tick4", {31'd0, tick[0]}, 32'd1);
            if (k == 24) chk("sync_coincide24", {30'd0, tick[1:0]}, 32'd3);
        end

        // Reset mid-op: ch2 at cnt=7 with a pending write
        en = 4'b0100;
        measure(2, n);
        repeat (6) step();
        cfg_valid = 1; cfg_ch = 2; cfg_div = 5; cfg_mode = 1;
        step();
        cfg_valid = 0;
        rst = 1;
        step();
        rst = 0;
        chk("rst_outputs", {24'd0, tick, div_out}, 32'd0);
        #1 chk("rst_pend_dropped", {31'd0, cfg_ready}, 32'd1);
        measure(2, n);
        chk("rst_resume_period", n, 16);

        // Randomized traffic against the model
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < NUM_CH; i++) en[i] = ($urandom_range(0, 7) != 0);
            cfg_valid = ($urandom_range(0, 3) == 0);
            cfg_ch    = 2'($urandom_range(0, 3));
            cfg_div   = DIV_W'($urandom_range(0, 12));
            cfg_mode  = 1'($urandom);
            sync      = ($urandom_range(0, 63) == 0);
            rst       = ($urandom_range(0, 499) == 0);
            step();
        end
        rst = 0; sync = 0; cfg_valid = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
